// File: rtl/crg_pkg.sv
// Shared types and default timing constants for the clock/reset sequencer.
// Contents: sequencer state encoding, default cycle counts, max helper.
package crg_pkg;

    typedef enum logic [2:0] {
        RST_MMCM  = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        ENABLE    = 3'd3,
        RUN       = 3'd4,
        SW_GATE   = 3'd5,
        SW_HOLD   = 3'd6
    } crg_state_e;

    // Defaults shared with the CRG wrapper generator
    localparam int unsigned CRG_NUM_CLK      = 4;
    localparam int unsigned CRG_SEL_IDX      = 1;
    localparam int unsigned CRG_RST_CYC      = 16;
    localparam int unsigned CRG_LOCK_TIMEOUT = 4096;
    localparam int unsigned CRG_SETTLE_CYC   = 64;
    localparam int unsigned CRG_STAGGER_CYC  = 8;
    localparam int unsigned CRG_SWITCH_CYC   = 8;
    localparam int unsigned CRG_CNT_W        = 16;

    function automatic int unsigned crg_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crg_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk_i (dest clock), rst_ni (async active-low reset, output clears to 0),
//        d_i (async input), q_o (synchronised output, 2-cycle latency).
module crg_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/crg_seq_ctrl.sv
// Power-up and run-time sequencer for the clock/reset generator.
// Runs on the free-running reference clock and drives the MMCM reset, the
// per-clock BUFGCE enables and the clk1 BUFGMUX select.
// Ports:
//   clk_src       free-running reference clock
//   rst_n_sys     asynchronous active-low reset
//   mmcm_locked   MMCM lock, asynchronous to clk_src
//   clk_en_req    per-clock run-time enable request
//   clk1_sel_req  requested BUFGMUX select
//   mmcm_reset    MMCM reset, active high
//   clk_gce       BUFGCE enables
//   clk1_sel      applied BUFGMUX select
//   crg_ready     bring-up complete, clocks follow requests
//   switch_busy   mux switch in progress
//   lock_err      one-cycle pulse on lock loss or lock timeout
module crg_seq_ctrl
    import crg_pkg::*;
#(
    parameter int unsigned NUM_CLK      = CRG_NUM_CLK,
    parameter int unsigned SEL_IDX      = CRG_SEL_IDX,
    parameter int unsigned RST_CYC      = CRG_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT = CRG_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYC   = CRG_SETTLE_CYC,
    parameter int unsigned STAGGER_CYC  = CRG_STAGGER_CYC,
    parameter int unsigned SWITCH_CYC   = CRG_SWITCH_CYC,
    parameter int unsigned CNT_W        = CRG_CNT_W
) (
    input  logic               clk_src,
    input  logic               rst_n_sys,
    input  logic               mmcm_locked,
    input  logic [NUM_CLK-1:0] clk_en_req,
    input  logic               clk1_sel_req,
    output logic               mmcm_reset,
    output logic [NUM_CLK-1:0] clk_gce,
    output logic               clk1_sel,
    output logic               crg_ready,
    output logic               switch_busy,
    output logic               lock_err
);

    localparam int unsigned MAX_CYC =
        crg_max(crg_max(crg_max(RST_CYC, LOCK_TIMEOUT), crg_max(SETTLE_CYC, STAGGER_CYC)),
                SWITCH_CYC);

    // Elaboration-time parameter sanity
    if (64'(MAX_CYC) > (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("crg_seq_ctrl: CNT_W too narrow for the largest cycle count");
    end
    if (SEL_IDX >= NUM_CLK) begin : g_bad_sel_idx
        $error("crg_seq_ctrl: SEL_IDX out of range");
    end
    if (RST_CYC == 0 || LOCK_TIMEOUT == 0 || SETTLE_CYC == 0 ||
        STAGGER_CYC == 0 || SWITCH_CYC == 0) begin : g_bad_cyc
        $error("crg_seq_ctrl: cycle counts must be at least 1");
    end

    crg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CLK-1:0] en_mask_q, en_mask_d;
    logic [NUM_CLK-1:0] gce_q, gce_d;
    logic               sel_q, sel_d;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               lock_err_q, lock_err_d;
    logic               lock_s;

    crg_sync2 u_lock_sync (
        .clk_i  (clk_src),
        .rst_ni (rst_n_sys),
        .d_i    (mmcm_locked),
        .q_o    (lock_s)
    );

    // State, counter and output registers
    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state_q    <= RST_MMCM;
            cnt_q      <= '0;
            en_mask_q  <= '0;
            gce_q      <= '0;
            sel_q      <= 1'b0;
            mmcm_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_mask_q  <= en_mask_d;
            gce_q      <= gce_d;
            sel_q      <= sel_d;
            mmcm_rst_q <= mmcm_rst_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_mask_d  = en_mask_q;
        sel_d      = sel_q;
        lock_err_d = 1'b0;

        unique case (state_q)
            RST_MMCM: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = WAIT_LOCK;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = SETTLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d    = RST_MMCM;
                    lock_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    en_mask_d = NUM_CLK'(1);
                    state_d   = en_mask_d[NUM_CLK-1] ? RUN : ENABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ENABLE: begin
                // Thermometer fill from bit 0 upward; last bit hands over to RUN
                if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
                    en_mask_d = (en_mask_q << 1) | NUM_CLK'(1);
                    cnt_d     = '0;
                    if (en_mask_d[NUM_CLK-1]) state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (clk1_sel_req != sel_q) state_d = SW_GATE;
            end
            SW_GATE: begin
                if (cnt_q == CNT_W'(SWITCH_CYC - 1)) begin
                    state_d = SW_HOLD;
                    sel_d   = ~sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SW_HOLD: begin
                if (cnt_q == CNT_W'(SWITCH_CYC - 1)) state_d = RUN;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = RST_MMCM;
        endcase

        // Lock loss once past WAIT_LOCK overrides everything; the mux select is left alone
        if (!lock_s && (state_q inside {SETTLE, ENABLE, RUN, SW_GATE, SW_HOLD})) begin
            state_d    = RST_MMCM;
            en_mask_d  = '0;
            sel_d      = sel_q;
            lock_err_d = 1'b1;
        end

        if (state_d != state_q) cnt_d = '0;

        gce_d = en_mask_d & clk_en_req;
        if (state_d inside {SW_GATE, SW_HOLD}) gce_d[SEL_IDX] = 1'b0;

        mmcm_rst_d = (state_d == RST_MMCM);
        ready_d    = (state_d inside {RUN, SW_GATE, SW_HOLD});
        busy_d     = (state_d inside {SW_GATE, SW_HOLD});
    end

    assign mmcm_reset  = mmcm_rst_q;
    assign clk_gce     = gce_q;
    assign clk1_sel    = sel_q;
    assign crg_ready   = ready_q;
    assign switch_busy = busy_q;
    assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_crg_seq_ctrl.sv
// Scoreboard bench for crg_seq_ctrl: stimulus queues per-cycle expected output
// snapshots, a negedge monitor compares them against the live outputs.
module tb_crg_seq_ctrl;

    logic       clk_src      = 1'b0;
    logic       rst_n_sys    = 1'b0;
    logic       mmcm_locked  = 1'b0;
    logic [3:0] clk_en_req   = 4'b1111;
    logic       clk1_sel_req = 1'b0;
    logic       mmcm_reset;
    logic [3:0] clk_gce;
    logic       clk1_sel;
    logic       crg_ready;
    logic       switch_busy;
    logic       lock_err;

    crg_seq_ctrl dut (
        .clk_src      (clk_src),
        .rst_n_sys    (rst_n_sys),
        .mmcm_locked  (mmcm_locked),
        .clk_en_req   (clk_en_req),
        .clk1_sel_req (clk1_sel_req),
        .mmcm_reset   (mmcm_reset),
        .clk_gce      (clk_gce),
        .clk1_sel     (clk1_sel),
        .crg_ready    (crg_ready),
        .switch_busy  (switch_busy),
        .lock_err     (lock_err)
    );

    always #5 clk_src = ~clk_src;

    // Snapshot layout: {mmcm_reset, clk_gce[3:0], clk1_sel, crg_ready, switch_busy, lock_err}
    localparam logic [8:0] ALL      = 9'h1FF;
    localparam logic [8:0] M_RST    = 9'h100;
    localparam logic [8:0] M_KEEP   = 9'h0D0;

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] exp;
        logic [8:0] care;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   started  = 1'b0;
    logic [8:0] snap;

    assign snap = {mmcm_reset, clk_gce, clk1_sel, crg_ready, switch_busy, lock_err};

    always @(posedge clk_src) if (started) cyc <= cyc + 1;

    function automatic logic [8:0] mk(input logic mr, input logic [3:0] g, input logic s,
                                      input logic r, input logic b, input logic e);
        return {mr, g, s, r, b, e};
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [8:0] e,
                             input logic [8:0] care);
        exp_t x;
        x.cyc = c; x.name = nm; x.exp = e; x.care = care;
        sb_q.push_back(x);
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge clk_src);
    endtask

    // Monitor: compare every entry due this cycle, flag any that slipped past
    always @(negedge clk_src) begin
        if (started) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc) begin
                    n_checks++;
                    if (sb_q[i].cyc == cyc && ((snap & sb_q[i].care) === (sb_q[i].exp & sb_q[i].care)))
                        n_pass++;
                    else
                        $display("FAIL %s cyc=%0d got=%b exp=%b care=%b",
                                 sb_q[i].name, sb_q[i].cyc, snap, sb_q[i].exp, sb_q[i].care);
                    sb_q.delete(i);
                end
            end
        end
    end

    initial begin
        // Bring-up: lock arrives 100 cycles after reset release
        expect_at(1,   "reset_state",     mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(15,  "mmcm_rst_hold",   mk(1, 4'b0000, 0, 0, 0, 0), M_RST);
        expect_at(16,  "mmcm_rst_fall",   mk(0, 4'b0000, 0, 0, 0, 0), M_RST);
        expect_at(102, "wait_lock_idle",  mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(166, "settle_gce_off",  mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(167, "gce_bit0",        mk(0, 4'b0001, 0, 0, 0, 0), ALL);
        expect_at(174, "gce_bit0_hold",   mk(0, 4'b0001, 0, 0, 0, 0), ALL);
        expect_at(175, "gce_bit1",        mk(0, 4'b0011, 0, 0, 0, 0), ALL);
        expect_at(183, "gce_bit2",        mk(0, 4'b0111, 0, 0, 0, 0), ALL);
        expect_at(190, "ready_not_yet",   mk(0, 4'b0111, 0, 0, 0, 0), ALL);
        expect_at(191, "gce_bit3_ready",  mk(0, 4'b1111, 0, 1, 0, 0), ALL);

        repeat (3) @(posedge clk_src);
        @(negedge clk_src);
        rst_n_sys = 1'b1;
        started   = 1'b1;
        wait_neg(100);
        n_checks++;
        if (mmcm_reset === 1'b0 && clk_gce === 4'b0000) n_pass++;
        else $display("FAIL wait_lock_direct cyc=%0d mmcm_reset=%b clk_gce=%b", cyc, mmcm_reset, clk_gce);
        mmcm_locked = 1'b1;

        // Mux switch 0 -> 1
        expect_at(200, "run_before_sw",   mk(0, 4'b1111, 0, 1, 0, 0), ALL);
        expect_at(201, "sw_gate_off",     mk(0, 4'b1101, 0, 1, 1, 0), ALL);
        expect_at(208, "sw_gate_end",     mk(0, 4'b1101, 0, 1, 1, 0), ALL);
        expect_at(209, "sw_sel_flip",     mk(0, 4'b1101, 1, 1, 1, 0), ALL);
        expect_at(216, "sw_hold_end",     mk(0, 4'b1101, 1, 1, 1, 0), ALL);
        expect_at(217, "sw_done",         mk(0, 4'b1111, 1, 1, 0, 0), ALL);
        for (int c = 201; c <= 217; c++)
            expect_at(c, "others_kept",   mk(0, 4'b1101, 0, 0, 0, 0), M_KEEP);
        wait_neg(200);
        n_checks++;
        if (crg_ready === 1'b1 && clk_gce === 4'b1111) n_pass++;
        else $display("FAIL run_direct cyc=%0d crg_ready=%b clk_gce=%b", cyc, crg_ready, clk_gce);
        clk1_sel_req = 1'b1;

        // Request flips back mid-switch: first switch completes, then toggle-back
        expect_at(231, "sw2_gate",        mk(0, 4'b1101, 1, 1, 1, 0), ALL);
        expect_at(238, "sw2_gate_end",    mk(0, 4'b1101, 1, 1, 1, 0), ALL);
        expect_at(239, "sw2_sel_flip",    mk(0, 4'b1101, 0, 1, 1, 0), ALL);
        expect_at(247, "sw2_done",        mk(0, 4'b1111, 0, 1, 0, 0), ALL);
        expect_at(248, "sw3_start",       mk(0, 4'b1101, 0, 1, 1, 0), ALL);
        expect_at(255, "sw3_gate_end",    mk(0, 4'b1101, 0, 1, 1, 0), ALL);
        expect_at(256, "sw3_sel_flip",    mk(0, 4'b1101, 1, 1, 1, 0), ALL);
        expect_at(264, "sw3_done",        mk(0, 4'b1111, 1, 1, 0, 0), ALL);
        wait_neg(230);
        clk1_sel_req = 1'b0;
        wait_neg(234);
        clk1_sel_req = 1'b1;

        // Run-time enable request
        expect_at(270, "req_all",         mk(0, 4'b1111, 1, 1, 0, 0), ALL);
        expect_at(271, "req2_drop",       mk(0, 4'b1011, 1, 1, 0, 0), ALL);
        expect_at(276, "req2_back",       mk(0, 4'b1111, 1, 1, 0, 0), ALL);
        wait_neg(270);
        clk_en_req = 4'b1011;
        wait_neg(275);
        clk_en_req = 4'b1111;

        // Lock loss in RUN, then recovery
        expect_at(292, "pre_lock_loss",   mk(0, 4'b1111, 1, 1, 0, 0), ALL);
        expect_at(293, "lock_loss",       mk(1, 4'b0000, 1, 0, 0, 1), ALL);
        expect_at(294, "lock_err_1cyc",   mk(1, 4'b0000, 1, 0, 0, 0), ALL);
        expect_at(308, "rerst_hold",      mk(1, 4'b0000, 1, 0, 0, 0), ALL);
        expect_at(309, "rerst_fall",      mk(0, 4'b0000, 1, 0, 0, 0), ALL);
        expect_at(386, "rebring_settle",  mk(0, 4'b0000, 1, 0, 0, 0), ALL);
        expect_at(387, "rebring_bit0",    mk(0, 4'b0001, 1, 0, 0, 0), ALL);
        expect_at(395, "rebring_bit1",    mk(0, 4'b0011, 1, 0, 0, 0), ALL);
        expect_at(399, "mid_enable",      mk(0, 4'b0011, 1, 0, 0, 0), ALL);
        wait_neg(290);
        mmcm_locked = 1'b0;
        wait_neg(320);
        mmcm_locked = 1'b1;

        // Async reset mid-ENABLE, then bring-up with lock already present
        expect_at(400, "async_rst",       mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(405, "in_rst",          mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(425, "post_rst_hold",   mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(426, "post_rst_fall",   mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(490, "post_rst_settle", mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(491, "post_rst_bit0",   mk(0, 4'b0001, 0, 0, 0, 0), ALL);
        expect_at(499, "post_rst_bit1",   mk(0, 4'b0011, 0, 0, 0, 0), ALL);
        expect_at(502, "pre_loss_enable", mk(0, 4'b0011, 0, 0, 0, 0), ALL);
        wait_neg(399);
        @(posedge clk_src);
        #2 rst_n_sys = 1'b0;
        wait_neg(410);
        rst_n_sys = 1'b1;

        // Lock lost during ENABLE and never returns: repeated timeouts
        expect_at(503,  "enable_loss",    mk(1, 4'b0000, 0, 0, 0, 1), ALL);
        expect_at(504,  "enable_loss_1c", mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(518,  "retry_hold",     mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(519,  "retry_fall",     mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(4614, "to_before",      mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(4615, "timeout1",       mk(1, 4'b0000, 0, 0, 0, 1), ALL);
        expect_at(4616, "timeout1_1c",    mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(4630, "to_rst_hold",    mk(1, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(4631, "to_rst_fall",    mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(8726, "to2_before",     mk(0, 4'b0000, 0, 0, 0, 0), ALL);
        expect_at(8727, "timeout2",       mk(1, 4'b0000, 0, 0, 0, 1), ALL);
        wait_neg(500);
        mmcm_locked = 1'b0;

        wait_neg(8735);
        n_checks++;
        if (mmcm_reset === 1'b1 && crg_ready === 1'b0) n_pass++;
        else $display("FAIL retry_direct cyc=%0d mmcm_reset=%b crg_ready=%b", cyc, mmcm_reset, crg_ready);
        @(negedge clk_src);
        // Anything still queued was never compared
        while (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL %s cyc=%0d got=unreached exp=%b", sb_q[0].name, sb_q[0].cyc, sb_q[0].exp);
            void'(sb_q.pop_front());
        end
        if (n_pass != n_checks) $display("FAIL summary: %0d failing checks", n_checks - n_pass);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
